regfile_mp: RTL and testbench

- Parametrised multi-port general-purpose register file; successor to the single-write, dual-read core register file.
- Configurable data width, register count, read-port count and write-port count.
- Adds a per-register busy scoreboard for dual-issue / multi-writeback pipelines.
- Sits between decode (read, allocate) and writeback (write, release).

---
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports and the busy-scoreboard allocate port.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2
);
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  alloc;
  logic [ADDR_W-1:0]     alloc_addr;
  logic                  busy_any;

  modport master (
    output we, waddr, wdata, raddr, alloc, alloc_addr,
    input  rdata, rbusy, busy_any
  );

  modport slave (
    input  we, waddr, wdata, raddr, alloc, alloc_addr,
    output rdata, rbusy, busy_any
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic                  busy_any_q;
  logic [NRD*DATA_W-1:0] rdata_c;
  logic [NRD-1:0]        rbusy_c;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Next state: writes in ascending port order so the highest port wins; alloc applied last.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (bus.we[k] && !is_zero_reg(bus.waddr[k*ADDR_W +: ADDR_W])) begin
        mem_d[bus.waddr[k*ADDR_W +: ADDR_W]]  = bus.wdata[k*DATA_W +: DATA_W];
        busy_d[bus.waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (bus.alloc && !is_zero_reg(bus.alloc_addr)) begin
      busy_d[bus.alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  // Read ports: pre-edge state, optionally overridden by a same-cycle write.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int j = 0; j < NRD; j++) begin
      rdata_c[j*DATA_W +: DATA_W] = mem_q[bus.raddr[j*ADDR_W +: ADDR_W]];
      rbusy_c[j]                  = busy_q[bus.raddr[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k] && (bus.waddr[k*ADDR_W +: ADDR_W] == bus.raddr[j*ADDR_W +: ADDR_W])) begin
          rdata_c[j*DATA_W +: DATA_W] = bus.wdata[k*DATA_W +: DATA_W];
          rbusy_c[j]                  = 1'b0;
        end
      end
`endif
      if (is_zero_reg(bus.raddr[j*ADDR_W +: ADDR_W])) begin
        rdata_c[j*DATA_W +: DATA_W] = '0;
        rbusy_c[j]                  = 1'b0;
      end
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.busy_any = busy_any_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, both REGFILE_BYPASS_EN builds).
module tb_regfile_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(2), .NWR(2), .ZERO_REG(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we    = 2'b00;
    bus.alloc = 1'b0;
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    bus.we[port]                = 1'b1;
    bus.waddr[port*ADDR_W +: ADDR_W] = a;
    bus.wdata[port*DATA_W +: DATA_W] = d;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.raddr = {a1, a0};
    #1;
  endtask

  initial begin
    bus.we = '0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    bus.alloc = 1'b0; bus.alloc_addr = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state across all indices on both ports
    check("rst_busy_any", 32'(bus.busy_any), 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check($sformatf("rst_rdata0[%0d]", i), bus.rdata[31:0], 32'd0);
      check($sformatf("rst_rdata1[%0d]", 31 - i), bus.rdata[63:32], 32'd0);
      check($sformatf("rst_rbusy[%0d]", i), 32'(bus.rbusy), 32'd0);
    end

    // Single write, same-cycle and next-cycle visibility
    wr(0, 5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd6);
    check("wr5_same_cycle", bus.rdata[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    tick(); idle(); rd(5'd5, 5'd5);
    check("wr5_next_p0", bus.rdata[31:0], 32'hDEADBEEF);
    check("wr5_next_p1_dup", bus.rdata[63:32], 32'hDEADBEEF);

    // Write conflict: highest port wins
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
    rd(5'd7, 5'd0);
    check("conf7_same_cycle", bus.rdata[31:0], BYP ? 32'h22 : 32'h0);
    tick(); idle(); rd(5'd7, 5'd7);
    check("conf7_p0", bus.rdata[31:0], 32'h22);
    check("conf7_p1", bus.rdata[63:32], 32'h22);

    // Two ports, distinct addresses
    wr(0, 5'd10, 32'h0000_0101); wr(1, 5'd11, 32'h0000_0202);
    tick(); idle(); rd(5'd10, 5'd11);
    check("dual_wr_10", bus.rdata[31:0], 32'h101);
    check("dual_wr_11", bus.rdata[63:32], 32'h202);

    // Register 0 hardwired: write and alloc ignored
    wr(0, 5'd0, 32'h1234); bus.alloc = 1'b1; bus.alloc_addr = 5'd0;
    rd(5'd0, 5'd5);
    check("zero_same_rdata", bus.rdata[31:0], 32'h0);
    check("zero_same_rbusy", 32'(bus.rbusy[0]), 32'd0);
    tick(); idle(); rd(5'd0, 5'd0);
    check("zero_rdata", bus.rdata[31:0], 32'h0);
    check("zero_rbusy", 32'(bus.rbusy), 32'd0);
    check("zero_busy_any", 32'(bus.busy_any), 32'd0);

    // Allocate idx9; alloc never shows on rbusy in its own cycle
    bus.alloc = 1'b1; bus.alloc_addr = 5'd9;
    rd(5'd5, 5'd9);
    check("alloc9_same_rbusy", 32'(bus.rbusy[1]), 32'd0);
    check("alloc9_same_busy_any", 32'(bus.busy_any), 32'd0);
    tick(); idle(); rd(5'd5, 5'd9);
    check("alloc9_rbusy", 32'(bus.rbusy[1]), 32'd1);
    check("alloc9_rbusy_other", 32'(bus.rbusy[0]), 32'd0);
    check("alloc9_busy_any", 32'(bus.busy_any), 32'd1);

    // Writeback releases idx9
    wr(1, 5'd9, 32'h55);
    rd(5'd5, 5'd9);
    check("wb9_same_rbusy", 32'(bus.rbusy[1]), BYP ? 32'd0 : 32'd1);
    check("wb9_same_rdata", bus.rdata[63:32], BYP ? 32'h55 : 32'h0);
    tick(); idle(); rd(5'd5, 5'd9);
    check("wb9_rbusy", 32'(bus.rbusy[1]), 32'd0);
    check("wb9_rdata", bus.rdata[63:32], 32'h55);
    check("wb9_busy_any", 32'(bus.busy_any), 32'd0);

    // Alloc and write same index: new producer wins, data still written
    wr(0, 5'd9, 32'h55); bus.alloc = 1'b1; bus.alloc_addr = 5'd9;
    tick(); idle(); rd(5'd9, 5'd5);
    check("aw9_rbusy", 32'(bus.rbusy[0]), 32'd1);
    check("aw9_rdata", bus.rdata[31:0], 32'h55);
    check("aw9_busy_any", 32'(bus.busy_any), 32'd1);

    // State before mid-operation reset
    wr(0, 5'd3, 32'hA); bus.alloc = 1'b1; bus.alloc_addr = 5'd4;
    tick(); idle(); rd(5'd3, 5'd4);
    check("pre_rst_rdata3", bus.rdata[31:0], 32'hA);
    check("pre_rst_rbusy4", 32'(bus.rbusy[1]), 32'd1);

    // Reset overrides a concurrent write and alloc
    rst = 1'b1; wr(0, 5'd3, 32'hB); bus.alloc = 1'b1; bus.alloc_addr = 5'd12;
    tick(); rst = 1'b0; idle(); rd(5'd3, 5'd4);
    check("post_rst_rdata3", bus.rdata[31:0], 32'h0);
    check("post_rst_rbusy4", 32'(bus.rbusy[1]), 32'd0);
    check("post_rst_busy_any", 32'(bus.busy_any), 32'd0);
    rd(5'd9, 5'd12);
    check("post_rst_rdata9", bus.rdata[31:0], 32'h0);
    check("post_rst_rbusy9_12", 32'(bus.rbusy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
